// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - shared constants and state encoding for the imem program loader
// IMEM_LOADER_CHECKSUM_EN adds the CKSUM state.
package imem_program_loader_pkg;

  localparam int HDR_W   = 16;
  localparam int BYTE_W  = 8;
  localparam int CKSUM_W = BYTE_W;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CKSUM  = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - packs accepted bytes big-endian into 32-bit words
// Emits a registered one-cycle word-valid pulse after the 4th byte of each word.
module loader_word_assembler
  import imem_program_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_last,
  output logic              o_word_valid,
  output logic [31:0]       o_word
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_hold;
  logic        r_word_valid;
  logic [31:0] r_word;

  assign o_last       = i_accept && (r_byte_cnt == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byte_cnt   <= 2'd0;
      r_hold       <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= 32'd0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_byte_cnt <= 2'd0;
        r_hold     <= 24'd0;
      end else if (i_accept) begin
        // First byte of a word ends up in [31:24].
        if (r_byte_cnt == 2'd3) begin
          r_word       <= {r_hold, i_byte};
          r_word_valid <= 1'b1;
        end else begin
          r_hold <= {r_hold[15:0], i_byte};
        end
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - loads instruction memory from a byte stream, then releases the CPU
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int IMEM_AW        = $clog2(INSTR_MEM_SIZE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               start,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset_n,
  output logic               done,
  output logic               error
);

  localparam int WCW = IMEM_AW + 1;
  localparam logic [HDR_W-1:0] MAX_N = HDR_W'(INSTR_MEM_SIZE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_IMAGE_END = S_CKSUM;
`else
  localparam state_e S_IMAGE_END = S_DONE;
`endif

  state_e             r_state;
  state_e             w_state_next;
  logic [7:0]         r_hdr_hi;
  logic [HDR_W-1:0]   r_count_n;
  logic [WCW-1:0]     r_word_cnt;
  logic [IMEM_AW-1:0] r_imem_addr;
  logic               r_done;
  logic               r_error;
  logic               r_cpu_run;
  logic               w_accept;
  logic               w_restart;
  logic               w_data_accept;
  logic               w_word_last;
  logic               w_last_word;
  logic [HDR_W-1:0]   w_n_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CKSUM_W-1:0] r_xor;
`endif

  assign in_ready      = (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_accept      = in_valid && in_ready;
  assign w_restart     = start && !in_ready;
  assign w_data_accept = w_accept && (r_state == S_DATA);
  assign w_n_hdr       = {r_hdr_hi, in_data};
  assign w_last_word   = ({{(HDR_W-WCW){1'b0}}, r_word_cnt} == (r_count_n - HDR_W'(1)));

  assign imem_addr   = r_imem_addr;
  assign cpu_reset_n = r_cpu_run;
  assign done        = r_done;
  assign error       = r_error;

  loader_word_assembler u_word_asm (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_restart),
    .i_accept     (w_data_accept),
    .i_byte       (in_data),
    .o_last       (w_word_last),
    .o_word_valid (imem_we),
    .o_word       (imem_wdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_HDR_HI;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HDR_HI: if (w_accept) w_state_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_n_hdr > MAX_N)     w_state_next = S_ERROR;
          else if (w_n_hdr == '0)  w_state_next = S_IMAGE_END;
          else                     w_state_next = S_DATA;
        end
      end
      S_DATA: if (w_word_last && w_last_word) w_state_next = S_IMAGE_END;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (w_accept) w_state_next = ((r_xor ^ in_data) == '0) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE, S_ERROR: if (start) w_state_next = S_HDR_HI;
      default: w_state_next = S_HDR_HI;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hdr_hi    <= 8'd0;
      r_count_n   <= '0;
      r_word_cnt  <= '0;
      r_imem_addr <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_run   <= 1'b0;
    end else begin
      if (w_restart) begin
        r_hdr_hi    <= 8'd0;
        r_count_n   <= '0;
        r_word_cnt  <= '0;
        r_imem_addr <= '0;
      end else if (w_accept) begin
        if (r_state == S_HDR_HI) r_hdr_hi  <= in_data;
        if (r_state == S_HDR_LO) r_count_n <= w_n_hdr;
        if (w_word_last) begin
          r_imem_addr <= r_word_cnt[IMEM_AW-1:0];
          r_word_cnt  <= r_word_cnt + WCW'(1);
        end
      end
      // Status flags track the state being entered so they rise on the deciding edge.
      r_done    <= (w_state_next == S_DONE);
      r_error   <= (w_state_next == S_ERROR);
      r_cpu_run <= (w_state_next == S_DONE);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_xor <= '0;
    else if (w_restart) r_xor <= '0;
    else if (w_accept)  r_xor <= r_xor ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - self-checking bench for imem_program_loader
// Frames are built from the frame rules and compared against captured imem writes.
module tb_imem_program_loader;

  localparam int SIZE = 32;
  localparam int AW   = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset_n;
  logic          done;
  logic          error;

  imem_program_loader #(.INSTR_MEM_SIZE(SIZE)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .start       (start),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    bit          exp_err;
    int          exp_writes;
    bit          poke_start;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         got_q[$];
  logic [31:0] img_q[$];
  logic [31:0] mem_img [0:SIZE-1];
  logic [7:0]  run_xor;
  vec_t        vecs[8];

  always @(negedge clock) begin
    if (reset && imem_we) begin
      got_q.push_back('{addr: int'(imem_addr), data: imem_wdata});
      mem_img[imem_addr] = imem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int bound;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    bound = 0;
    repeat (gap) begin @(posedge clock); #1; end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && bound < 8) begin @(posedge clock); #1; bound++; end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_byte_timeout actual=%h required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    run_xor  = run_xor ^ b;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] n, input bit exp_err, input int exp_writes,
                           input int max_gap, input bit poke_start);
    got_q.delete();
    run_xor = 8'd0;
    send_byte(n[15:8], max_gap);
    send_byte(n[7:0], max_gap);
    if (exp_err) begin
      check("hdr_err_error", {31'd0, error}, 32'd1);
      check("hdr_err_in_ready", {31'd0, in_ready}, 32'd0);
      check("hdr_err_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
      check("hdr_err_done", {31'd0, done}, 32'd0);
      repeat (2) begin @(posedge clock); #1; end
      check("hdr_err_writes", got_q.size(), 32'd0);
      return;
    end
    if (poke_start) pulse_start();
    for (int w = 0; w < exp_writes; w++) begin
      for (int k = 3; k >= 0; k--) begin
        logic [31:0] word;
        word = img_q[w];
        send_byte(word[k*8 +: 8], max_gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(run_xor, max_gap);
`endif
    check("frame_done", {31'd0, done}, 32'd1);
    check("frame_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);
    check("frame_error", {31'd0, error}, 32'd0);
    check("frame_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1;
    check("frame_write_count", got_q.size(), exp_writes);
    for (int i = 0; i < got_q.size() && i < exp_writes; i++) begin
      check($sformatf("frame_addr_%0d", i), got_q[i].addr, i);
      check($sformatf("frame_data_%0d", i), got_q[i].data, img_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 16'd5,      exp_err: 1'b0, exp_writes: 5,  poke_start: 1'b0};
    vecs[1] = '{n: 16'd0,      exp_err: 1'b0, exp_writes: 0,  poke_start: 1'b0};
    vecs[2] = '{n: 16'd33,     exp_err: 1'b1, exp_writes: 0,  poke_start: 1'b0};
    vecs[3] = '{n: 16'd32,     exp_err: 1'b0, exp_writes: 32, poke_start: 1'b0};
    vecs[4] = '{n: 16'd1,      exp_err: 1'b0, exp_writes: 1,  poke_start: 1'b1};
    vecs[5] = '{n: 16'h0100,   exp_err: 1'b1, exp_writes: 0,  poke_start: 1'b0};
    vecs[6] = '{n: 16'd2,      exp_err: 1'b0, exp_writes: 2,  poke_start: 1'b1};
    vecs[7] = '{n: 16'd31,     exp_err: 1'b0, exp_writes: 31, poke_start: 1'b0};
    for (int i = 0; i < SIZE; i++) mem_img[i] = 32'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {27'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Lab-8 style program with fixed words.
    img_q = '{32'h00c00913, 32'h01202823, 32'h01002983, 32'h00000013, 32'h0000006f};
    run_frame(16'd5, 1'b0, 5, 0, 1'b0);
    pulse_start();

    // Fixed words with random valid gaps.
    img_q = '{32'hDEADBEEF, 32'h01234567};
    run_frame(16'd2, 1'b0, 2, 3, 1'b0);

    for (int v = 0; v < 8; v++) begin
      if (done || error) pulse_start();
      check("vec_idle_done", {31'd0, done}, 32'd0);
      check("vec_idle_in_ready", {31'd0, in_ready}, 32'd1);
      img_q.delete();
      for (int w = 0; w < vecs[v].exp_writes; w++) img_q.push_back($urandom);
      run_frame(vecs[v].n, vecs[v].exp_err, vecs[v].exp_writes, 3, vecs[v].poke_start);
    end

    // Reset mid-load: one full word and two bytes of the next, then reset.
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    got_q.delete();
    run_xor = 8'd0;
    mem_img[1] = 32'h5A5A5A5A;
    foreach (img_q[i]) img_q.delete(i);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    check("midrst_imem_we", {31'd0, imem_we}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_pre_writes", got_q.size(), 32'd1);
    check("midrst_pre_word0", mem_img[0], 32'h11223344);
    got_q.delete();
    run_xor = 8'd0;
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    check("lat_imem_we", {31'd0, imem_we}, 32'd1);
    check("lat_imem_addr", {27'd0, imem_addr}, 32'd0);
    check("lat_imem_wdata", imem_wdata, 32'hAABBCCDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(run_xor, 0);
`else
    @(posedge clock); #1;
`endif
    check("lat_we_one_cycle", {31'd0, imem_we}, 32'd0);
    check("midrst_writes", got_q.size(), 32'd1);
    check("midrst_word0", mem_img[0], 32'hAABBCCDD);
    check("midrst_word1_untouched", mem_img[1], 32'h5A5A5A5A);
    check("midrst_done", {31'd0, done}, 32'd1);
    check("midrst_cpu_run", {31'd0, cpu_reset_n}, 32'd1);
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    check("restart_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Total XOR over 00 01 11 22 33 44 is 45, so 45 closes the frame and 44 does not.
    run_xor = 8'd0;
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h45, 0);
    check("cksum_good_done", {31'd0, done}, 32'd1);
    check("cksum_good_error", {31'd0, error}, 32'd0);
    pulse_start();
    run_xor = 8'd0;
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    check("cksum_bad_error", {31'd0, error}, 32'd1);
    check("cksum_bad_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    check("cksum_bad_done", {31'd0, done}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
